// File: rtl/imu_frame_deser.sv
// imu_frame_deser: serial-to-parallel deserializer for IMU burst frames.
// Shifts NUM_CH channels of CH_W bits (MSB first, channel 0 first) into a
// shadow register and publishes the complete frame atomically on o_frame_data.
// Optional mid-frame watchdog: define FRAME_TIMEOUT_EN to enable it.
module imu_frame_deser #(
    parameter int NUM_CH = 9,
    parameter int CH_W   = 16,
    parameter int CNT_W  = 8
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_bit_valid,
    input  logic                     i_bit_data,
    input  logic                     i_frame_start,
    output logic [NUM_CH*CH_W-1:0]   o_frame_data,
    output logic                     o_frame_valid,
    output logic [CNT_W-1:0]         o_frame_cnt,
    output logic                     o_busy,
    output logic                     o_err_abort,
    output logic                     o_err_timeout
);

    localparam int FRAME_W = NUM_CH * CH_W;
    localparam int BCW     = $clog2(FRAME_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shadow;
    logic [FRAME_W-1:0] r_frame_data;
    logic [BCW-1:0]     r_bit_cnt;
    logic               r_frame_valid;
    logic               r_err_abort;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic [FRAME_W-1:0] w_shadow_next;
    logic [FRAME_W-1:0] w_start_shadow;
    logic [FRAME_W-1:0] w_remap;
    logic [BCW-1:0]     w_start_cnt;

`ifdef FRAME_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC - 1);

    logic [TCW-1:0]     r_to_cnt;
    logic               r_err_timeout;
`endif

    // Shadow image with the current bit written at its frame position (channel 0 on top).
    always_comb begin
        w_shadow_next = r_shadow;
        w_shadow_next[LAST_BIT - r_bit_cnt] = i_bit_data;
    end

    // Fresh shadow and bit counter for a frame start, taking bit 0 if it arrives with the start strobe.
    always_comb begin
        w_start_shadow = '0;
        w_start_shadow[FRAME_W-1] = i_bit_valid & i_bit_data;
        w_start_cnt = i_bit_valid ? BCW'(1) : '0;
    end

    // Remap shadow (channel 0 at the top) so channel k lands at [k*CH_W +: CH_W].
    for (genvar k = 0; k < NUM_CH; k++) begin : g_remap
        assign w_remap[k*CH_W +: CH_W] = w_shadow_next[FRAME_W-1-k*CH_W -: CH_W];
    end

    // Frame FSM: collects bits, publishes on the accepting edge so o_frame_valid is high during LOAD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_frame_data  <= '0;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
            r_err_abort   <= 1'b0;
            r_frame_cnt   <= '0;
`ifdef FRAME_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            r_err_abort   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_state   <= S_SHIFT;
                        r_shadow  <= w_start_shadow;
                        r_bit_cnt <= w_start_cnt;
`ifdef FRAME_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end
                end

                S_SHIFT: begin
                    if (i_frame_start) begin
                        r_err_abort <= 1'b1;
                        r_shadow    <= w_start_shadow;
                        r_bit_cnt   <= w_start_cnt;
`ifdef FRAME_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end else if (i_bit_valid) begin
`ifdef FRAME_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        r_shadow <= w_shadow_next;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state       <= S_LOAD;
                            r_bit_cnt     <= '0;
                            r_frame_data  <= w_remap;
                            r_frame_valid <= 1'b1;
                            r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end
`ifdef FRAME_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                        r_shadow      <= '0;
                        r_bit_cnt     <= '0;
                        r_to_cnt      <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TCW'(1);
                    end
`endif
                end

                S_LOAD: begin
                    if (i_frame_start) begin
                        r_state   <= S_SHIFT;
                        r_shadow  <= w_start_shadow;
                        r_bit_cnt <= w_start_cnt;
`ifdef FRAME_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_frame_data  = r_frame_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_busy        = (r_state != S_IDLE);
    assign o_err_abort   = r_err_abort;
`ifdef FRAME_TIMEOUT_EN
    assign o_err_timeout = r_err_timeout;
`else
    assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imu_frame_deser.sv
// tb_imu_frame_deser: directed self-checking bench for imu_frame_deser.
// Frames are held in output layout (channel k at [k*16 +: 16]) and serialised
// MSB first, channel 0 first. Honours FRAME_TIMEOUT_EN for the watchdog step.
module tb_imu_frame_deser;

   localparam int NUM_CH  = 9;
   localparam int CH_W    = 16;
   localparam int CNT_W   = 8;
   localparam int FRAME_W = NUM_CH * CH_W;

   logic               clock = 1'b0;
   logic               rstN;
   logic               bitValid;
   logic               bitData;
   logic               frameStart;
   logic [FRAME_W-1:0] frameData;
   logic               frameValid;
   logic [CNT_W-1:0]   frameCnt;
   logic               busy;
   logic               errAbort;
   logic               errTimeout;

   int passCount  = 0;
   int totalCount = 0;

   imu_frame_deser #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk         (clock),
      .i_rst_n       (rstN),
      .i_bit_valid   (bitValid),
      .i_bit_data    (bitData),
      .i_frame_start (frameStart),
      .o_frame_data  (frameData),
      .o_frame_valid (frameValid),
      .o_frame_cnt   (frameCnt),
      .o_busy        (busy),
      .o_err_abort   (errAbort),
      .o_err_timeout (errTimeout)
   );

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   // Serial bit i of a frame: channel i/16, MSB first within the channel.
   function automatic logic bitOf(input logic [FRAME_W-1:0] f, input int i);
      return f[(i / CH_W) * CH_W + (CH_W - 1) - (i % CH_W)];
   endfunction

   // Drive one cycle of inputs, then return 1 time unit after the rising edge.
   task automatic applyStimulus(input logic fs, input logic bv, input logic bd);
      frameStart = fs;
      bitValid   = bv;
      bitData    = bd;
      @(posedge clock);
      #1;
   endtask

   // Compare an observed value against the bench's expected value.
   task automatic checkOutput(input string tag, input logic [FRAME_W-1:0] observed,
                              input logic [FRAME_W-1:0] expected);
      totalCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Send serial bits first..last of frame f, with frame_start on the first one if requested.
   task automatic sendBits(input logic [FRAME_W-1:0] f, input int first, input int last,
                           input logic withStart);
      for (int i = first; i <= last; i++) begin
         applyStimulus(withStart && (i == first), 1'b1, bitOf(f, i));
      end
   endtask

   logic [FRAME_W-1:0] f1;
   logic [FRAME_W-1:0] fJunk;
   logic [FRAME_W-1:0] fA5;
   logic [FRAME_W-1:0] fj;
   logic [CNT_W-1:0]   expCnt;
   logic               sawBusy;
   logic               sawValid;
   int                 validCount;
   int                 toSeen;
   int                 toAt;

   initial begin
      frameStart = 1'b0;
      bitValid   = 1'b0;
      bitData    = 1'b0;
      rstN       = 1'b1;

      for (int k = 0; k < NUM_CH; k++) begin
         f1[k*CH_W +: CH_W] = 16'h1000 + 16'(k) * 16'h0111;
      end
      f1[15:0]    = 16'h1234;
      f1[143:128] = 16'hBEEF;
      fJunk = {FRAME_W{1'b1}};
      fA5   = {NUM_CH{16'hA5A5}};

      // Step 0: asynchronous reset.
      #2 rstN = 1'b0;
      #10;
      checkOutput("reset frame_data", frameData, '0);
      checkOutput("reset frame_valid", FRAME_W'(frameValid), '0);
      checkOutput("reset frame_cnt", FRAME_W'(frameCnt), '0);
      checkOutput("reset busy", FRAME_W'(busy), '0);
      checkOutput("reset err_abort", FRAME_W'(errAbort), '0);
      checkOutput("reset err_timeout", FRAME_W'(errTimeout), '0);
      @(posedge clock);
      #1 rstN = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Step 1: one full frame started from IDLE.
      $display("[TB] step 1: single frame");
      sendBits(f1, 0, FRAME_W - 2, 1'b1);
      checkOutput("f1 no early valid", FRAME_W'(frameValid), '0);
      checkOutput("f1 busy mid", FRAME_W'(busy), 1);
      sendBits(f1, FRAME_W - 1, FRAME_W - 1, 1'b0);
      checkOutput("f1 valid", FRAME_W'(frameValid), 1);
      checkOutput("f1 data", frameData, f1);
      checkOutput("f1 ch0", FRAME_W'(frameData[15:0]), FRAME_W'(16'h1234));
      checkOutput("f1 ch8", FRAME_W'(frameData[143:128]), FRAME_W'(16'hBEEF));
      checkOutput("f1 cnt", FRAME_W'(frameCnt), 1);
      checkOutput("f1 busy in load", FRAME_W'(busy), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("f1 valid one cycle", FRAME_W'(frameValid), '0);
      checkOutput("f1 idle busy", FRAME_W'(busy), '0);
      checkOutput("f1 data hold", frameData, f1);

      // Step 2: 40 stale bits, then a restart with bit 0 in the same cycle.
      $display("[TB] step 2: abort and restart");
      sendBits(fJunk, 0, 39, 1'b1);
      checkOutput("abort pre busy", FRAME_W'(busy), 1);
      applyStimulus(1'b1, 1'b1, bitOf(fA5, 0));
      checkOutput("abort pulse", FRAME_W'(errAbort), 1);
      checkOutput("abort no valid", FRAME_W'(frameValid), '0);
      checkOutput("abort data kept", frameData, f1);
      checkOutput("abort cnt kept", FRAME_W'(frameCnt), 1);
      sendBits(fA5, 1, 1, 1'b0);
      checkOutput("abort pulse ends", FRAME_W'(errAbort), '0);
      sendBits(fA5, 2, FRAME_W - 2, 1'b0);
      checkOutput("a5 data not early", frameData, f1);
      checkOutput("a5 no early valid", FRAME_W'(frameValid), '0);
      sendBits(fA5, FRAME_W - 1, FRAME_W - 1, 1'b0);
      checkOutput("a5 valid", FRAME_W'(frameValid), 1);
      checkOutput("a5 data", frameData, fA5);
      checkOutput("a5 cnt", FRAME_W'(frameCnt), 2);
      checkOutput("a5 no abort", FRAME_W'(errAbort), '0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Step 3: bits without frame_start while IDLE are ignored.
      $display("[TB] step 3: stray bits in idle");
      sawBusy  = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 1'b1, 1'(i % 3 == 0));
         if (busy)       sawBusy  = 1'b1;
         if (frameValid) sawValid = 1'b1;
      end
      checkOutput("idle bits busy", FRAME_W'(sawBusy), '0);
      checkOutput("idle bits valid", FRAME_W'(sawValid), '0);
      checkOutput("idle bits data", frameData, fA5);
      checkOutput("idle bits cnt", FRAME_W'(frameCnt), 2);

      // Step 4: 256 back-to-back frames, each started in its predecessor's LOAD cycle.
      $display("[TB] step 4: 256 back-to-back frames");
      expCnt     = 8'd2;
      validCount = 0;
      for (int j = 0; j < 256; j++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            fj[k*CH_W +: CH_W] = {8'(j), 8'(k * 29 + 3)};
         end
         for (int i = 0; i < FRAME_W; i++) begin
            applyStimulus(i == 0, 1'b1, bitOf(fj, i));
            if (frameValid) validCount++;
         end
         expCnt = expCnt + 8'd1;
         checkOutput("b2b data", frameData, fj);
         checkOutput("b2b cnt", FRAME_W'(frameCnt), FRAME_W'(expCnt));
      end
      checkOutput("b2b valid count", FRAME_W'(validCount), 256);
      checkOutput("b2b cnt wrapped", FRAME_W'(frameCnt), 2);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("b2b idle busy", FRAME_W'(busy), '0);

      // Step 5: asynchronous reset in the middle of a frame.
      $display("[TB] step 5: reset mid-frame");
      sendBits(f1, 0, 69, 1'b1);
      #2 rstN = 1'b0;
      frameStart = 1'b0;
      bitValid   = 1'b0;
      #1;
      checkOutput("midrst data", frameData, '0);
      checkOutput("midrst cnt", FRAME_W'(frameCnt), '0);
      checkOutput("midrst busy", FRAME_W'(busy), '0);
      checkOutput("midrst valid", FRAME_W'(frameValid), '0);
      @(posedge clock);
      #1 rstN = 1'b1;
      sawBusy  = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         if (busy)       sawBusy  = 1'b1;
         if (frameValid) sawValid = 1'b1;
      end
      checkOutput("postrst busy", FRAME_W'(sawBusy), '0);
      checkOutput("postrst valid", FRAME_W'(sawValid), '0);
      checkOutput("postrst data", frameData, '0);
      checkOutput("postrst cnt", FRAME_W'(frameCnt), '0);

      // Step 6: stall mid-frame for 4096 idle cycles.
      $display("[TB] step 6: stalled frame");
      sendBits(f1, 0, 9, 1'b1);
      toSeen = 0;
      toAt   = 0;
      for (int n = 1; n <= 4096; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (errTimeout) begin
            toSeen++;
            toAt = n;
         end
      end
`ifdef FRAME_TIMEOUT_EN
      checkOutput("timeout pulses", FRAME_W'(toSeen), 1);
      checkOutput("timeout cycle", FRAME_W'(toAt), 4096);
      checkOutput("timeout busy", FRAME_W'(busy), '0);
      checkOutput("timeout cnt", FRAME_W'(frameCnt), '0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("timeout pulse ends", FRAME_W'(errTimeout), '0);
`else
      checkOutput("stall no timeout", FRAME_W'(toSeen), '0);
      checkOutput("stall timeout cycle", FRAME_W'(toAt), '0);
      checkOutput("stall busy", FRAME_W'(busy), 1);
      checkOutput("stall cnt", FRAME_W'(frameCnt), '0);
`endif

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
